// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and parity polarity
// (the receive-side checker uses the same EVEN/ODD constants).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity bit for one payload word: even = ^data, odd = ~^data.
module uart_tx_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  parity_type_i,
  output logic                  parity_o
);

  always_comb begin
    parity_o = ^data_i;
    if (parity_type_i == ODD_PARITY) parity_o = ~parity_o;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start / LSB-first data / optional parity / stop frame on tx_out.
// Define UART_TX_STOP2_EN for two stop bits; the default build sends one.
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0)
// DATA   | payload bits, LSB first
// PARITY | latched parity bit
// STOP   | stop bit(s) (1)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
`ifdef UART_TX_STOP2_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  uart_tx_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit_gen;
  logic                  bit_end;

  uart_tx_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i        (p_data),
    .parity_type_i (parity_type),
    .parity_o      (par_bit_gen)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: if (data_valid) begin
        state_d   = START;
        cnt_d     = '0;
        idx_d     = '0;
        stop_d    = 1'b0;
        shift_d   = p_data;
        par_en_d  = parity_enable;
        par_bit_d = par_bit_gen;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        if (idx_q == IDX_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        if (stop_q == STOP_LAST) state_d = IDLE;
        else stop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decided from next state so tx_out comes straight off a flop.
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a bit-list frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;
  logic          tx_out;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic exp_q[$];
  logic obs_q[$];

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .tx_out        (tx_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Model: list the frame's bits, then stretch each to CPB line cycles.
  function automatic void build_expected(input logic [DW-1:0] d, input logic pen,
                                         input logic ptype);
    logic bits[$];
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ ptype);
    for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
    foreach (bits[b]) for (int k = 0; k < CPB; k++) exp_q.push_back(bits[b]);
  endfunction

  // Called at a negedge; returns at the negedge of the first START cycle.
  task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptype);
    p_data = d; parity_enable = pen; parity_type = ptype; data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Records tx_out each busy cycle while scrambling inputs; optional late request.
  task automatic capture(input int inject_at);
    int n = 0;
    obs_q.delete();
    while (busy === 1'b1 && n < 200) begin
      obs_q.push_back(tx_out);
      p_data = DW'($urandom);
      parity_enable = 1'($urandom);
      parity_type = 1'($urandom);
      data_valid = (n == inject_at);
      if (n == inject_at) p_data = 8'h3C;
      n++;
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: tx=%b busy=%b expected 1/0", tx_out, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: tx=%b busy=%b expected 1/0", tx_out, busy);
    end
    build_expected(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (tx_out !== exp_q[10] || busy !== 1'b1) begin
      errors++; $display("FAIL reset_premid: tx=%b busy=%b expected %b/1", tx_out, busy, exp_q[10]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: tx=%b busy=%b expected 1/0", tx_out, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3 * 44) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_no_restart: %0d non-idle cycles expected 0", bad);
    end
  endtask

  task automatic test_even_parity();
    build_expected(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    capture(-1);
    checks++;
    if (obs_q.size() != (1 + DW + 1 + STOP_BITS) * CPB) begin
      errors++; $display("FAIL even_len: got %0d expected %0d", obs_q.size(), (1 + DW + 1 + STOP_BITS) * CPB);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL even_line cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() > 36 && obs_q[36] !== 1'b0) begin
      errors++; $display("FAIL even_parity_bit: got %b expected 0", obs_q[36]);
    end
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL even_end: tx=%b busy=%b expected 1/0", tx_out, busy);
    end
  endtask

  task automatic test_odd_parity();
    build_expected(8'h01, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    capture(-1);
    checks++;
    if (obs_q.size() != (1 + DW + 1 + STOP_BITS) * CPB) begin
      errors++; $display("FAIL odd_len: got %0d expected %0d", obs_q.size(), (1 + DW + 1 + STOP_BITS) * CPB);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL odd_line cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() > 36 && obs_q[36] !== 1'b0) begin
      errors++; $display("FAIL odd_parity_bit: got %b expected 0", obs_q[36]);
    end
  endtask

  task automatic test_no_parity();
    build_expected(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    capture(-1);
    checks++;
    if (obs_q.size() != (1 + DW + STOP_BITS) * CPB) begin
      errors++; $display("FAIL nopar_len: got %0d expected %0d", obs_q.size(), (1 + DW + STOP_BITS) * CPB);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL nopar_line cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_drop();
    int bad = 0;
    build_expected(8'h96, 1'b1, 1'b1);
    send(8'h96, 1'b1, 1'b1);
    capture(8);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop_len: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL drop_line cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    repeat (2 * 48) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop_queued: %0d non-idle cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, len1;
    build_expected(8'h5A, 1'b0, 1'b0);
    len1 = exp_q.size();
    send(8'h5A, 1'b0, 1'b0);
    s1 = cyc;
    capture(-1);
    checks++;
    if (obs_q.size() != len1) begin
      errors++; $display("FAIL b2b_len1: got %0d expected %0d", obs_q.size(), len1);
    end
    build_expected(8'hC3, 1'b1, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    s2 = cyc;
    checks++;
    if (s2 - s1 != len1 + 1) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected %0d", s2 - s1, len1 + 1);
    end
    capture(-1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_len2: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_line cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic pen, ptype;
    for (int f = 0; f < 16; f++) begin
      d = DW'($urandom);
      pen = 1'($urandom);
      ptype = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      build_expected(d, pen, ptype);
      send(d, pen, ptype);
      capture(-1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_len f%0d: got %0d expected %0d", f, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_line f%0d cyc %0d: got %b expected %b", f, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_busy_drop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
